// File: rtl/control_card_if.sv
// ============================================================================
// Module      : control_card_if
// Description : Bus bundle between the control card and the other cards:
//               data/leq flow into the control card, ctrl/halted/instr_done
//               flow out of it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DATAWIDTH
`define DATAWIDTH 8
`endif
`ifndef CTRLWIDTH
`define CTRLWIDTH 16
`endif

interface control_card_if #(
    parameter int DATAWIDTH = `DATAWIDTH,
    parameter int CTRLWIDTH = `CTRLWIDTH
);
    logic [DATAWIDTH-1:0] data;
    logic                 leq;
    logic [CTRLWIDTH-1:0] ctrl;
    logic                 halted;
    logic                 instr_done;

    // The control card drives the control bus and status flags
    modport master (
        input  data,
        input  leq,
        output ctrl,
        output halted,
        output instr_done
    );

    // The rest of the machine drives data and the ALU flag
    modport slave (
        output data,
        output leq,
        input  ctrl,
        input  halted,
        input  instr_done
    );
endinterface

`default_nettype wire

// File: rtl/control_card.sv
// ============================================================================
// Module      : control_card
// Description : Sequencer for a SUBLEQ-style machine. Walks every instruction
//               through FA,INC1,FB,INC2,RDA,RDB,WRB then BR or INC3 and
//               drives the registered control bus for each step.
//               Optional macro CTRL_HALT_EN: a branch target of 0 stops the
//               machine in HALT until reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DATAWIDTH
`define DATAWIDTH 8
`endif
`ifndef CTRLWIDTH
`define CTRLWIDTH 16
`endif

module control_card #(
    parameter int DATAWIDTH = `DATAWIDTH,
    parameter int CTRLWIDTH = `CTRLWIDTH
) (
    input  wire logic      clk,
    input  wire logic      rst,
    control_card_if.master bus
);

    // Control bus field positions
    localparam int c_wr_lsb  = 0;   // CTRL_REG_WR[1:0]
    localparam int c_rd_lsb  = 2;   // CTRL_REG_RD[1:0]
    localparam int c_mem_rd  = 4;
    localparam int c_mem_wr  = 5;
    localparam int c_inc_oe  = 6;
    localparam int c_alu_lda = 7;
    localparam int c_alu_ldb = 8;
    localparam int c_alu_oe  = 9;

    // Register select codes
    localparam logic [1:0] c_reg_none = 2'd0;
    localparam logic [1:0] c_reg_pc   = 2'd1;
    localparam logic [1:0] c_reg_a    = 2'd2;
    localparam logic [1:0] c_reg_b    = 2'd3;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        FA   = 4'd1,
        INC1 = 4'd2,
        FB   = 4'd3,
        INC2 = 4'd4,
        RDA  = 4'd5,
        RDB  = 4'd6,
        WRB  = 4'd7,
        BR   = 4'd8,
        INC3 = 4'd9,
        HALT = 4'd10
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [CTRLWIDTH-1:0] r_ctrl;
    logic                 r_done;
    logic [DATAWIDTH-1:0] w_data;

    assign w_data = bus.data;

    // Control word for a state; only one data-bus source is ever enabled
    function automatic logic [CTRLWIDTH-1:0] ctrl_of(input state_t s);
        logic [CTRLWIDTH-1:0] c;
        c = '0;
        case (s)
            FA: begin
                c[c_rd_lsb +: 2] = c_reg_pc;
                c[c_mem_rd]      = 1'b1;
                c[c_wr_lsb +: 2] = c_reg_a;
            end
            FB: begin
                c[c_rd_lsb +: 2] = c_reg_pc;
                c[c_mem_rd]      = 1'b1;
                c[c_wr_lsb +: 2] = c_reg_b;
            end
            INC1, INC2, INC3: begin
                c[c_rd_lsb +: 2] = c_reg_pc;
                c[c_inc_oe]      = 1'b1;
                c[c_wr_lsb +: 2] = c_reg_pc;
            end
            RDA: begin
                c[c_rd_lsb +: 2] = c_reg_a;
                c[c_mem_rd]      = 1'b1;
                c[c_alu_lda]     = 1'b1;
            end
            RDB: begin
                c[c_rd_lsb +: 2] = c_reg_b;
                c[c_mem_rd]      = 1'b1;
                c[c_alu_ldb]     = 1'b1;
            end
            WRB: begin
                c[c_rd_lsb +: 2] = c_reg_b;
                c[c_alu_oe]      = 1'b1;
                c[c_mem_wr]      = 1'b1;
            end
            BR: begin
                c[c_rd_lsb +: 2] = c_reg_pc;
                c[c_mem_rd]      = 1'b1;
                c[c_wr_lsb +: 2] = c_reg_pc;
            end
            default: c[c_wr_lsb +: 2] = c_reg_none;
        endcase
        return c;
    endfunction

    // Next-state decode; leq only matters while leaving WRB
    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE: w_next = FA;
            FA:   w_next = INC1;
            INC1: w_next = FB;
            FB:   w_next = INC2;
            INC2: w_next = RDA;
            RDA:  w_next = RDB;
            RDB:  w_next = WRB;
            WRB:  w_next = bus.leq ? BR : INC3;
`ifdef CTRL_HALT_EN
            BR:   w_next = (w_data == '0) ? HALT : FA;
            HALT: w_next = HALT;
`else
            BR:   w_next = FA;
`endif
            INC3: w_next = FA;
            default: w_next = IDLE;
        endcase
    end

    // State and all outputs registered together so ctrl is settled by negedge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ctrl  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ctrl  <= ctrl_of(w_next);
            r_done  <= (r_state == BR) || (r_state == INC3);
        end
    end

    assign bus.ctrl       = r_ctrl;
    assign bus.instr_done = r_done;

`ifdef CTRL_HALT_EN
    logic r_halted;

    // Halt flag tracks entry into the HALT state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_halted <= 1'b0;
        end else begin
            r_halted <= (w_next == HALT);
        end
    end

    assign bus.halted = r_halted;
`else
    logic w_unused_data;

    // Data bus is only inspected by the halt check
    assign w_unused_data = ^w_data;
    assign bus.halted    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_control_card.sv
// ============================================================================
// Module      : tb_control_card
// Description : Self-checking bench for control_card; vector tables run
//               through a scoreboard queue plus reset and halt sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_card;

    localparam int DW = 8;
    localparam int CW = 16;

    // Expected control words, bit map: wr[1:0] rd[3:2] mem_rd4 mem_wr5
    // inc_oe6 alu_lda7 alu_ldb8 alu_oe9; reg codes none0 pc1 a2 b3
    localparam logic [CW-1:0] E_ZERO = 16'h0000;
    localparam logic [CW-1:0] E_FA   = 16'h0016;
    localparam logic [CW-1:0] E_INC  = 16'h0045;
    localparam logic [CW-1:0] E_FB   = 16'h0017;
    localparam logic [CW-1:0] E_RDA  = 16'h0098;
    localparam logic [CW-1:0] E_RDB  = 16'h011C;
    localparam logic [CW-1:0] E_WRB  = 16'h022C;
    localparam logic [CW-1:0] E_BR   = 16'h0015;

    typedef struct {
        logic          leq;
        logic [DW-1:0] data;
        logic [CW-1:0] ctrl;
        logic          done;
        logic          halted;
        string         name;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];
    vec_t sb[$];

    control_card_if #(.DATAWIDTH(DW), .CTRLWIDTH(CW)) bus ();

    control_card #(.DATAWIDTH(DW), .CTRLWIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one vector, push its expectation, compare after the next edge
    task automatic run_vec(input vec_t v);
        vec_t e;
        bus.leq  = v.leq;
        bus.data = v.data;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.name, ".ctrl"},   bus.ctrl, e.ctrl);
        chk({e.name, ".done"},   {15'd0, bus.instr_done}, {15'd0, e.done});
        chk({e.name, ".halted"}, {15'd0, bus.halted},     {15'd0, e.halted});
    endtask

    task automatic add(input logic l, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic dn, input logic h, input string n);
        vec_t v;
        v.leq = l; v.data = d; v.ctrl = c; v.done = dn; v.halted = h; v.name = n;
        tbl.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.leq  = 1'b0;
        bus.data = 8'h33;

        // leq held 0: one full instruction through INC3
        add(0, 8'h33, E_FA,  0, 0, "a_fa");
        add(0, 8'h33, E_INC, 0, 0, "a_inc1");
        add(0, 8'h33, E_FB,  0, 0, "a_fb");
        add(0, 8'h33, E_INC, 0, 0, "a_inc2");
        add(0, 8'h33, E_RDA, 0, 0, "a_rda");
        add(0, 8'h33, E_RDB, 0, 0, "a_rdb");
        add(0, 8'h33, E_WRB, 0, 0, "a_wrb");
        add(0, 8'h33, E_INC, 0, 0, "a_inc3");
        add(0, 8'h33, E_FA,  1, 0, "a_fa_next");
        add(0, 8'h33, E_INC, 0, 0, "a_inc1_next");
        // leq held 1 everywhere: only WRB reacts, branch target nonzero
        add(1, 8'h05, E_FB,  0, 0, "b_fb");
        add(1, 8'h05, E_INC, 0, 0, "b_inc2");
        add(1, 8'h05, E_RDA, 0, 0, "b_rda");
        add(1, 8'h05, E_RDB, 0, 0, "b_rdb");
        add(1, 8'h05, E_WRB, 0, 0, "b_wrb");
        add(1, 8'h05, E_BR,  0, 0, "b_br");
        add(1, 8'h05, E_FA,  1, 0, "b_fa_next");
        add(1, 8'h05, E_INC, 0, 0, "b_inc1_next");
        // branch with data 0 leaving BR
        add(1, 8'h00, E_FB,  0, 0, "c_fb");
        add(1, 8'h00, E_INC, 0, 0, "c_inc2");
        add(1, 8'h00, E_RDA, 0, 0, "c_rda");
        add(1, 8'h00, E_RDB, 0, 0, "c_rdb");
        add(1, 8'h00, E_WRB, 0, 0, "c_wrb");
        add(1, 8'h00, E_BR,  0, 0, "c_br");
`ifdef CTRL_HALT_EN
        add(0, 8'h00, E_ZERO, 1, 1, "c_halt");
`else
        add(0, 8'h00, E_FA,   1, 0, "c_fa_nohalt");
`endif

        // Asynchronous reset before any clock edge
        #1 rst = 1'b1;
        #1;
        chk("reset.ctrl",   bus.ctrl, E_ZERO);
        chk("reset.done",   {15'd0, bus.instr_done}, 16'd0);
        chk("reset.halted", {15'd0, bus.halted},     16'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i]);
        end

`ifdef CTRL_HALT_EN
        // HALT must hold regardless of inputs
        for (int i = 0; i < 20; i++) begin
            vec_t v;
            v.leq = 1'($urandom_range(0, 1)); v.data = 8'($urandom);
            v.ctrl = E_ZERO; v.done = 1'b0; v.halted = 1'b1; v.name = "halt_hold";
            run_vec(v);
        end
`else
        begin
            vec_t v;
            v.leq = 1'b0; v.data = 8'h00; v.ctrl = E_INC; v.done = 1'b0;
            v.halted = 1'b0; v.name = "nohalt_inc1";
            run_vec(v);
        end
`endif

        // Restart, then abort mid-RDB with an asynchronous reset
        rst = 1'b1;
        #1;
        chk("rst2.ctrl",   bus.ctrl, E_ZERO);
        chk("rst2.halted", {15'd0, bus.halted}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        tbl.delete();
        add(0, 8'h11, E_FA,  0, 0, "d_fa");
        add(0, 8'h11, E_INC, 0, 0, "d_inc1");
        add(0, 8'h11, E_FB,  0, 0, "d_fb");
        add(0, 8'h11, E_INC, 0, 0, "d_inc2");
        add(0, 8'h11, E_RDA, 0, 0, "d_rda");
        add(0, 8'h11, E_RDB, 0, 0, "d_rdb");
        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i]);
        end
        #2 rst = 1'b1;
        #1;
        chk("abort.ctrl_before_edge", bus.ctrl, E_ZERO);
        chk("abort.done",             {15'd0, bus.instr_done}, 16'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("abort.held_ctrl", bus.ctrl, E_ZERO);
        end
        @(negedge clk);
        rst = 1'b0;
        begin
            vec_t v;
            v.leq = 1'b1; v.data = 8'h00; v.ctrl = E_FA; v.done = 1'b0;
            v.halted = 1'b0; v.name = "abort.fa_after_release";
            run_vec(v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
